// File: rtl/result_collect_buffer.sv
// result_collect_buffer: reorders the column-major drain stream into row-major result memory; define RESULT_SAT_EN for signed saturation
module result_collect_buffer #(
  parameter int N = 16,
  parameter int ACC_W = 32,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              drain_valid,
  input  logic [ACC_W-1:0]  drain_data,
  output logic              drain_ready,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              done,
  output logic              sat_flag
);
  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
  state_t state, state_nx;
  logic start_q, start_edge, accept, last;
  logic [ADDR_W-1:0] wr_cnt, wr_addr;
  logic [DATA_W-1:0] narrow;
  logic [DATA_W-1:0] mem [N*N];
  assign start_edge = start & ~start_q;
  assign drain_ready = state == FILL;
  assign accept = drain_valid & drain_ready & ~start_edge;
  assign last = wr_cnt == ADDR_W'(N*N-1);
  assign wr_addr = ADDR_W'((int'(wr_cnt) % N) * N + int'(wr_cnt) / N);
`ifdef RESULT_SAT_EN
  logic clamp;
  assign clamp = ~(&drain_data[ACC_W-1:DATA_W-1]) & (|drain_data[ACC_W-1:DATA_W-1]);
  assign narrow = clamp ? {drain_data[ACC_W-1], {(DATA_W-1){~drain_data[ACC_W-1]}}} : drain_data[DATA_W-1:0];
  // sticky saturation indicator, cleared by each new collection
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sat_flag <= 1'b0;
    else if (start_edge) sat_flag <= 1'b0;
    else if (accept & clamp) sat_flag <= 1'b1;
`else
  logic unused_hi;
  assign unused_hi = ^drain_data[ACC_W-1:DATA_W];
  assign narrow = drain_data[DATA_W-1:0];
  assign sat_flag = 1'b0;
`endif
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // next state: a start edge always (re)enters FILL, the last word ends it
  always_comb begin
    state_nx = state;
    if (start_edge) state_nx = FILL;
    else if (accept & last) state_nx = DONE;
  end
  // start edge detection, write counter and completion flag
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      start_q <= 1'b0;
      wr_cnt <= '0;
      done <= 1'b0;
    end else begin
      start_q <= start;
      if (start_edge) begin
        wr_cnt <= '0;
        done <= 1'b0;
      end else if (accept) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (last) done <= 1'b1;
      end
    end
  // transposing write: word k lands at row k%N, column k/N
  always_ff @(posedge clk)
    if (accept) mem[wr_addr] <= narrow;
  // registered read port, served only once the result is complete
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_data <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en & (state == DONE);
      if (rd_en & (state == DONE)) rd_data <= mem[rd_addr];
    end
endmodule

// File: tb/tb_result_collect_buffer.sv
// tb_result_collect_buffer: directed self-checking bench for result_collect_buffer
module tb_result_collect_buffer;
  logic clk = 0, rst_n = 0, start = 0, drain_valid = 0, rd_en = 0;
  logic [31:0] drain_data = '0;
  logic [7:0] rd_addr = '0;
  logic drain_ready, rd_valid, done, sat_flag;
  logic [15:0] rd_data;
  int total = 0, bad = 0;

  result_collect_buffer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .drain_valid(drain_valid),
    .drain_data(drain_data), .drain_ready(drain_ready), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .done(done), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic drain(input int n, input logic [31:0] v0, input int step);
    for (int k = 0; k < n; k++) begin
      drain_valid = 1;
      drain_data = v0 + 32'(k * step);
      tick();
    end
    drain_valid = 0;
  endtask

  task automatic rd_check(input logic [7:0] a, input logic [15:0] e, input string nm);
    rd_en = 1;
    rd_addr = a;
    tick();
    rd_en = 0;
    total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL %s_valid got=%b exp=1", nm, rd_valid); end
    total++; if (rd_data !== e) begin bad++; $display("FAIL %s_data got=%h exp=%h", nm, rd_data, e); end
  endtask

  task automatic test_reset;
    #1;
    total++; if (drain_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", drain_ready); end
    total++; if (rd_data !== 16'h0) begin bad++; $display("FAIL rst_rd_data got=%h exp=0000", rd_data); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL rst_rd_valid got=%b exp=0", rd_valid); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
    total++; if (sat_flag !== 1'b0) begin bad++; $display("FAIL rst_sat got=%b exp=0", sat_flag); end
    #12 rst_n = 1;
    tick();
  endtask

  task automatic test_idle_ignore;
    drain(3, 32'hBEEF, 0);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL idle_done got=%b exp=0", done); end
    total++; if (drain_ready !== 1'b0) begin bad++; $display("FAIL idle_ready got=%b exp=0", drain_ready); end
    rd_en = 1; rd_addr = 8'd5;
    tick();
    rd_en = 0;
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL idle_rd_valid got=%b exp=0", rd_valid); end
  endtask

  task automatic test_fill_ramp;
    pulse_start();
    total++; if (drain_ready !== 1'b1) begin bad++; $display("FAIL fill_ready got=%b exp=1", drain_ready); end
    drain(50, 32'd0, 1);
    rd_en = 1; rd_addr = 8'd5;
    tick();
    rd_en = 0;
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL fill_rd_valid got=%b exp=0", rd_valid); end
    total++; if (rd_data !== 16'h0) begin bad++; $display("FAIL fill_rd_data got=%h exp=0000", rd_data); end
    drain(205, 32'd50, 1);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL ramp_early_done got=%b exp=0", done); end
    drain(1, 32'd255, 1);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL ramp_done got=%b exp=1", done); end
    total++; if (drain_ready !== 1'b0) begin bad++; $display("FAIL done_ready got=%b exp=0", drain_ready); end
    rd_check(8'd0, 16'h0000, "ramp_a0");
    rd_check(8'd1, 16'h0010, "ramp_a1");
    rd_check(8'd16, 16'h0001, "ramp_a16");
    rd_check(8'd255, 16'h00FF, "ramp_a255");
  endtask

  task automatic test_back_to_back;
    rd_en = 1; rd_addr = 8'd2;
    tick();
    total++; if (rd_valid !== 1'b1 || rd_data !== 16'h0020) begin bad++; $display("FAIL b2b_a2 got=%b/%h exp=1/0020", rd_valid, rd_data); end
    rd_addr = 8'd3;
    tick();
    rd_en = 0;
    total++; if (rd_valid !== 1'b1 || rd_data !== 16'h0030) begin bad++; $display("FAIL b2b_a3 got=%b/%h exp=1/0030", rd_valid, rd_data); end
    tick();
    total++; if (rd_valid !== 1'b0 || rd_data !== 16'h0030) begin bad++; $display("FAIL b2b_hold got=%b/%h exp=0/0030", rd_valid, rd_data); end
  endtask

  task automatic test_narrow;
    logic [15:0] e0, e16;
    logic es;
`ifdef RESULT_SAT_EN
    e0 = 16'h7FFF; e16 = 16'h8000; es = 1'b1;
`else
    e0 = 16'h2345; e16 = 16'h0000; es = 1'b0;
`endif
    pulse_start();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL restart_done_fall got=%b exp=0", done); end
    drain(1, 32'h0001_2345, 0);
    drain(1, 32'hFFFF_0000, 0);
    drain(254, 32'd0, 0);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL narrow_done got=%b exp=1", done); end
    total++; if (sat_flag !== es) begin bad++; $display("FAIL narrow_sat got=%b exp=%b", sat_flag, es); end
    rd_check(8'd0, e0, "narrow_a0");
    rd_check(8'd16, e16, "narrow_a16");
  endtask

  task automatic test_restart_in_fill;
    pulse_start();
    total++; if (sat_flag !== 1'b0) begin bad++; $display("FAIL restart_sat_clear got=%b exp=0", sat_flag); end
    drain(100, 32'h1234, 0);
    drain_valid = 1; drain_data = 32'h5555; start = 1;
    tick();
    start = 0;
    drain(255, 32'hAAAA, 0);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL restart_early_done got=%b exp=0", done); end
    drain(1, 32'hAAAA, 0);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL restart_done got=%b exp=1", done); end
    for (int a = 0; a < 256; a++) rd_check(8'(a), 16'hAAAA, $sformatf("restart_a%0d", a));
  endtask

  task automatic test_async_reset;
    pulse_start();
    drain(50, 32'h100, 1);
    #2 rst_n = 0;
    #1;
    total++; if (drain_ready !== 1'b0) begin bad++; $display("FAIL arst_ready got=%b exp=0", drain_ready); end
    total++; if (rd_data !== 16'h0) begin bad++; $display("FAIL arst_rd_data got=%h exp=0000", rd_data); end
    total++; if (done !== 1'b0 || rd_valid !== 1'b0 || sat_flag !== 1'b0) begin bad++; $display("FAIL arst_flags got=%b%b%b exp=000", done, rd_valid, sat_flag); end
    #1 rst_n = 1;
    tick();
    pulse_start();
    drain(255, 32'h100, 1);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL arst_early_done got=%b exp=0", done); end
    drain(1, 32'h1FF, 1);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL arst_done got=%b exp=1", done); end
    rd_check(8'd1, 16'h0110, "arst_a1");
    rd_check(8'd17, 16'h0111, "arst_a17");
    rd_check(8'd32, 16'h0102, "arst_a32");
    rd_check(8'd255, 16'h01FF, "arst_a255");
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_fill_ramp();
    test_back_to_back();
    test_narrow();
    test_restart_in_fill();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/result_collect_buffer.md
Name: result_collect_buffer

Overview:
- Sits downstream of the systolic PE array inside top.
- Captures the column-major drain stream of 256 accumulator results and reorders it into row-major storage.
- Narrows each 32-bit accumulator to 16 bits.
- Serves the external output read port (addr_O/en_O → data_O/out_valid), and generates ap_done once the full 16x16 result is stored.

Parameters:
- N, 16, matrix dimension; the buffer holds N*N results.
- ACC_W, 32, width of incoming accumulator words.
- DATA_W, 16, width of stored and output words.
- ADDR_W, 8, read-address width; must equal log2(N*N).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  level from ap_start; a rising edge begins a new collection
- drain_valid  in  1  array presents a result this cycle
- drain_data  in  ACC_W  signed accumulator value
- drain_ready  out  1  buffer accepts; high only in FILL
- rd_en  in  1  read request (en_O)
- rd_addr  in  ADDR_W  row-major index, row*N+col (addr_O)
- rd_data  out  DATA_W  read result (data_O)
- rd_valid  out  1  rd_data is valid this cycle (out_valid)
- done  out  1  ap_done; full result stored
- sat_flag  out  1  sticky: saturation occurred during the current collection

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE, wr_cnt=0.
  - drain_ready=0, rd_data=0, rd_valid=0, done=0, sat_flag=0.
  - start edge register cleared. Memory array is not reset.
- States and transitions:
  - IDLE: start rising edge → FILL.
  - FILL: accept words; the 256th accepted word → DONE.
  - DONE: start rising edge → FILL.
- Start edge: start_q registers start; edge = start & ~start_q. The edge clears wr_cnt to 0, done to 0 and sat_flag to 0.
- Restart while in FILL: an edge restarts from wr_cnt=0; already-written entries are overwritten.
- Write rules:
  - Accept happens when drain_valid & drain_ready.
  - Word k (wr_cnt) is stored at mem[(k%N)*N + k/N]. The stream is column-major, so col = k/N and row = k%N.
  - drain_valid outside FILL is ignored.
  - drain_data holding is not required: one transfer per cycle.
- Done timing: done rises in the cycle after the 256th accept and stays high until the next start edge or reset.
- Read rules:
  - rd_en=1 in DONE → rd_data=mem[rd_addr] and rd_valid=1 on the next clock edge (1-cycle latency).
  - rd_en=0 or state≠DONE → rd_valid=0 next cycle; rd_data holds its last value.
  - Back-to-back reads are supported, one per cycle.
- Narrowing: default is truncation to drain_data[DATA_W-1:0] (see Optional Feature).
- Simultaneous start edge and accept in the same cycle: the start edge wins and the word is dropped. drain_ready is low in IDLE/DONE, so this only matters on a restart from FILL.
- Reset mid-FILL: returns to IDLE, and done stays 0 until a full new collection completes.

Optional Feature:
- Macro: RESULT_SAT_EN.
- Defined:
  - Signed saturation of drain_data to [-32768, 32767].
  - Any clamped accept sets sat_flag, which is sticky until the next start edge or reset.
- Undefined:
  - Truncation to the low DATA_W bits.
  - sat_flag is tied to 0.

Test Plan:
- Reset, then start edge, then drain k=0..255 with value k → done rises the cycle after the last accept. Reads at addr 0, 1, 16, 255 return 0x0000, 0x0010, 0x0001, 0x00FF, each with rd_valid one cycle after rd_en.
- rd_en asserted during FILL at addr 5 → rd_valid stays 0 and rd_data unchanged; drain_valid asserted in IDLE → no write, done stays 0.
- Drain 0x0001_2345 into k=0:
  - Without RESULT_SAT_EN → addr 0 reads 0x2345, sat_flag=0.
  - With RESULT_SAT_EN → reads 0x7FFF, sat_flag=1.
  - 0xFFFF_0000 → reads 0x8000.
- Restart edge after 100 accepts, then 256 accepts with value 0xAAAA → done=1 and all 256 addresses read 0xAAAA.
- Deassert rst_n mid-FILL (after 50 accepts) → outputs zero immediately, without waiting for a clock edge. A new start plus 256 accepts completes normally.
- After done, a second start edge → done falls the next cycle and sat_flag clears; the second data set is fully readable after its completion.
